sdes_decrypt_core: RTL and testbench

SDES_DECRYPT_CORE -- requirements
Module: sdes_decrypt_core

---
 rtl/sdes_pkg.sv | 99 +++++++++
 rtl/sdes_round.sv | 18 +
 rtl/sdes_decrypt_core.sv | 109 ++++++++++
 tb/tb_sdes_decrypt_core.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdes_pkg.sv
// sdes_pkg: shared types, tables and helper functions for the SDES core.
// Holds the FSM state type, permutation/S-box tables and bit helpers.
package sdes_pkg;

    localparam int KEY_W    = 10;
    localparam int BLK_W    = 8;
    localparam int SUBKEY_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEYGEN,
        S_RND1,
        S_RND2,
        S_DONE
    } state_t;

    // Tables use textbook 1-based numbering, bit 1 = MSB.
    localparam int P10_T [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    localparam int P8_T  [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};
    localparam int IP_T  [8]  = '{2, 6, 3, 1, 4, 8, 5, 7};
    localparam int IPI_T [8]  = '{4, 1, 3, 5, 7, 2, 8, 6};
    localparam int EP_T  [8]  = '{4, 1, 2, 3, 2, 3, 4, 1};
    localparam int P4_T  [4]  = '{2, 4, 3, 1};

    // Indexed by {row, col}.
    localparam logic [1:0] S0_T [16] = '{
        2'd1, 2'd0, 2'd3, 2'd2,
        2'd3, 2'd2, 2'd1, 2'd0,
        2'd0, 2'd2, 2'd1, 2'd3,
        2'd3, 2'd1, 2'd3, 2'd2
    };
    localparam logic [1:0] S1_T [16] = '{
        2'd0, 2'd1, 2'd2, 2'd3,
        2'd2, 2'd0, 2'd1, 2'd3,
        2'd3, 2'd0, 2'd1, 2'd0,
        2'd2, 2'd1, 2'd0, 2'd3
    };

    function automatic logic [KEY_W-1:0] p10(input logic [KEY_W-1:0] k);
        logic [KEY_W-1:0] o;
        o = '0;
        for (int i = 0; i < 10; i++) o[9-i] = k[10-P10_T[i]];
        return o;
    endfunction

    function automatic logic [SUBKEY_W-1:0] p8(input logic [KEY_W-1:0] k);
        logic [SUBKEY_W-1:0] o;
        o = '0;
        for (int i = 0; i < 8; i++) o[7-i] = k[10-P8_T[i]];
        return o;
    endfunction

    function automatic logic [BLK_W-1:0] ip(input logic [BLK_W-1:0] b);
        logic [BLK_W-1:0] o;
        o = '0;
        for (int i = 0; i < 8; i++) o[7-i] = b[8-IP_T[i]];
        return o;
    endfunction

    function automatic logic [BLK_W-1:0] ip_inv(input logic [BLK_W-1:0] b);
        logic [BLK_W-1:0] o;
        o = '0;
        for (int i = 0; i < 8; i++) o[7-i] = b[8-IPI_T[i]];
        return o;
    endfunction

    function automatic logic [7:0] ep(input logic [3:0] r);
        logic [7:0] o;
        o = '0;
        for (int i = 0; i < 8; i++) o[7-i] = r[4-EP_T[i]];
        return o;
    endfunction

    function automatic logic [3:0] p4(input logic [3:0] s);
        logic [3:0] o;
        o = '0;
        for (int i = 0; i < 4; i++) o[3-i] = s[4-P4_T[i]];
        return o;
    endfunction

    // row = nibble bits 1,4; col = bits 2,3 (MSB-first numbering).
    function automatic logic [1:0] sbox0(input logic [3:0] n);
        return S0_T[{n[3], n[0], n[2], n[1]}];
    endfunction

    function automatic logic [1:0] sbox1(input logic [3:0] n);
        return S1_T[{n[3], n[0], n[2], n[1]}];
    endfunction

    // Circular left shifts applied to each 5-bit half.
    function automatic logic [KEY_W-1:0] ls1(input logic [KEY_W-1:0] k);
        return {k[8:5], k[9], k[3:0], k[4]};
    endfunction

    function automatic logic [KEY_W-1:0] ls2(input logic [KEY_W-1:0] k);
        return {k[7:5], k[9:8], k[2:0], k[4:3]};
    endfunction

endpackage

// File: rtl/sdes_round.sv
// sdes_round: combinational fK round, (L,R) -> (L xor F(R,K), R).
// Ports: lr = {L,R}, subkey = round key, res = {L',R}.
module sdes_round
    import sdes_pkg::*;
(
    input  logic [BLK_W-1:0]    lr,
    input  logic [SUBKEY_W-1:0] subkey,
    output logic [BLK_W-1:0]    res
);

    logic [7:0] e;
    logic [3:0] f;

    assign e   = ep(lr[3:0]) ^ subkey;
    assign f   = p4({sbox0(e[7:4]), sbox1(e[3:0])});
    assign res = {lr[7:4] ^ f, lr[3:0]};

endmodule

// File: rtl/sdes_decrypt_core.sv
// sdes_decrypt_core: multi-cycle SDES decryptor with valid/ready handshakes.
// Ports: i_clk, i_rst_n (async low), i_valid/o_ready/i_cipher/i_key request,
//        o_valid/i_ready/o_plain result, o_busy. SDES_DEC_ENCRYPT_EN adds i_mode.
module sdes_decrypt_core
    import sdes_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [BLK_W-1:0] i_cipher,
    input  logic [KEY_W-1:0] i_key,
`ifdef SDES_DEC_ENCRYPT_EN
    input  logic             i_mode,
`endif
    output logic             o_valid,
    input  logic             i_ready,
    output logic [BLK_W-1:0] o_plain,
    output logic             o_busy
);

    state_t state;
    state_t state_nx;

    logic [BLK_W-1:0]    cipher_q;
    logic [KEY_W-1:0]    key_q;
    logic [SUBKEY_W-1:0] k1_q;
    logic [SUBKEY_W-1:0] k2_q;
    logic [BLK_W-1:0]    lr_q;
    logic                enc_q;

    logic                accept;
    logic                use_k2;
    logic [SUBKEY_W-1:0] subkey;
    logic [BLK_W-1:0]    rnd;

    assign accept = i_valid && (state == S_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (i_valid) state_nx = S_KEYGEN;
            S_KEYGEN: state_nx = S_RND1;
            S_RND1:   state_nx = S_RND2;
            S_RND2:   state_nx = S_DONE;
            S_DONE:   if (i_ready) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state == S_IDLE);
        o_valid = (state == S_DONE);
        o_busy  = (state != S_IDLE);
    end

`ifdef SDES_DEC_ENCRYPT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)    enc_q <= 1'b0;
        else if (accept) enc_q <= i_mode;
    end
`else
    assign enc_q = 1'b0;
`endif

    // Decrypt runs K2 then K1; encrypt swaps the order.
    assign use_k2 = (state == S_RND1) ^ enc_q;
    assign subkey = use_k2 ? k2_q : k1_q;

    sdes_round u_round (
        .lr     (lr_q),
        .subkey (subkey),
        .res    (rnd)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cipher_q <= '0;
            key_q    <= '0;
            k1_q     <= '0;
            k2_q     <= '0;
            lr_q     <= '0;
            o_plain  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        cipher_q <= i_cipher;
                        key_q    <= i_key;
                    end
                end
                S_KEYGEN: begin
                    k1_q <= p8(ls1(p10(key_q)));
                    k2_q <= p8(ls2(ls1(p10(key_q))));
                    lr_q <= ip(cipher_q);
                end
                S_RND1: lr_q <= {rnd[3:0], rnd[7:4]};
                S_RND2: o_plain <= ip_inv(rnd);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdes_decrypt_core.sv
// tb_sdes_decrypt_core: directed self-checking bench for sdes_decrypt_core.
// Known vectors, backpressure, reset, input hold-off and back-to-back runs.
module tb_sdes_decrypt_core;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       valid  = 1'b0;
    logic       ready  = 1'b1;
    logic [7:0] cipher = 8'h00;
    logic [9:0] key    = 10'h000;
`ifdef SDES_DEC_ENCRYPT_EN
    logic       mode   = 1'b0;
`endif
    logic       o_ready;
    logic       o_valid;
    logic       o_busy;
    logic [7:0] plain;

    int total = 0;
    int bad   = 0;

    localparam logic [9:0] KV = 10'b1010000010;
    localparam logic [7:0] CV = 8'b00111000;
    localparam logic [7:0] PV = 8'b10010111;

    always #5 clk = ~clk;

    sdes_decrypt_core dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (valid),
        .o_ready  (o_ready),
        .i_cipher (cipher),
        .i_key    (key),
`ifdef SDES_DEC_ENCRYPT_EN
        .i_mode   (mode),
`endif
        .o_valid  (o_valid),
        .i_ready  (ready),
        .o_plain  (plain),
        .o_busy   (o_busy)
    );

    // Independent reference model (textbook tables, 1-based bit numbers).
    int P10T [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    int P8T  [10] = '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0};
    int IPT  [10] = '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0};
    int IPIT [10] = '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0};
    int EPT  [10] = '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0};
    int P4T  [10] = '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0};
    int S0 [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
    int S1 [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

    function automatic logic [9:0] pick(input logic [9:0] v, input int n,
                                        input int m, input int t[10]);
        logic [9:0] o;
        o = '0;
        for (int i = 0; i < m; i++) o[m-1-i] = v[n-t[i]];
        return o;
    endfunction

    function automatic logic [7:0] fk(input logic [7:0] x, input logic [7:0] k);
        logic [9:0] e;
        logic [9:0] p;
        logic [1:0] a;
        logic [1:0] b;
        e = pick({6'd0, x[3:0]}, 4, 8, EPT) ^ {2'b00, k};
        a = 2'(S0[{e[7], e[4]}][{e[6], e[5]}]);
        b = 2'(S1[{e[3], e[0]}][{e[2], e[1]}]);
        p = pick({6'd0, a, b}, 4, 4, P4T);
        return {x[7:4] ^ p[3:0], x[3:0]};
    endfunction

    function automatic logic [7:0] model(input logic [7:0] c, input logic [9:0] k,
                                         input logic enc);
        logic [9:0] p;
        logic [9:0] s;
        logic [9:0] t;
        logic [7:0] k1;
        logic [7:0] k2;
        logic [9:0] x;
        p  = pick(k, 10, 10, P10T);
        s  = {p[8:5], p[9], p[3:0], p[4]};
        t  = {s[7:5], s[9:8], s[2:0], s[4:3]};
        p  = pick(s, 10, 8, P8T);
        k1 = p[7:0];
        p  = pick(t, 10, 8, P8T);
        k2 = p[7:0];
        x  = pick({2'b00, c}, 8, 8, IPT);
        x[7:0] = fk(x[7:0], enc ? k1 : k2);
        x[7:0] = {x[3:0], x[7:4]};
        x[7:0] = fk(x[7:0], enc ? k2 : k1);
        x  = pick({2'b00, x[7:0]}, 8, 8, IPIT);
        return x[7:0];
    endfunction

    task automatic accept_req(input logic [7:0] c, input logic [9:0] k,
                              input logic m);
        int n;
        n = 0;
        while (!o_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (o_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_wait o_ready=%0b want 1", o_ready);
        end
        cipher = c;
        key    = k;
`ifdef SDES_DEC_ENCRYPT_EN
        mode   = m;
`else
        if (m) cipher = c;
`endif
        valid  = 1'b1;
        @(posedge clk); #1;
        valid  = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!o_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (o_valid !== 1'b1) begin
            bad++;
            $display("FAIL wait_valid o_valid=%0b want 1", o_valid);
        end
    endtask

    task automatic run_one(input logic [7:0] c, input logic [9:0] k,
                           input logic m, output logic [7:0] r, output int lat);
        accept_req(c, k, m);
        wait_valid(lat);
        r = plain;
        ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if (o_ready !== 1'b1) begin
            bad++; $display("FAIL rst_ready got=%0b want=1", o_ready);
        end
        total++;
        if (o_valid !== 1'b0) begin
            bad++; $display("FAIL rst_valid got=%0b want=0", o_valid);
        end
        total++;
        if (o_busy !== 1'b0) begin
            bad++; $display("FAIL rst_busy got=%0b want=0", o_busy);
        end
        total++;
        if (plain !== 8'h00) begin
            bad++; $display("FAIL rst_plain got=%h want=00", plain);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_known();
        logic [7:0] r;
        int lat;
        ready = 1'b1;
        run_one(CV, KV, 1'b0, r, lat);
        total++;
        if (r !== PV) begin
            bad++; $display("FAIL known_plain got=%b want=%b", r, PV);
        end
        total++;
        if (lat + 1 !== 4) begin
            bad++; $display("FAIL known_latency got=%0d want=4", lat + 1);
        end
        total++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            bad++;
            $display("FAIL known_release rdy=%0b vld=%0b want 1 0", o_ready, o_valid);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        ready = 1'b0;
        accept_req(CV, KV, 1'b0);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total++;
            if (o_valid !== 1'b1 || plain !== PV || o_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d vld=%0b plain=%b rdy=%0b want 1 %b 0",
                         i, o_valid, plain, o_ready, PV);
            end
        end
        ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release vld=%0b rdy=%0b want 0 1", o_valid, o_ready);
        end
    endtask

    task automatic test_input_change();
        int lat;
        ready = 1'b1;
        accept_req(CV, KV, 1'b0);
        @(posedge clk); #1;
        cipher = 8'hFF;
        key    = 10'h3FF;
        wait_valid(lat);
        total++;
        if (plain !== PV) begin
            bad++; $display("FAIL input_change got=%b want=%b", plain, PV);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_done_valid();
        int lat;
        ready = 1'b1;
        accept_req(CV, KV, 1'b0);
        wait_valid(lat);
        cipher = CV;
        key    = KV;
        valid  = 1'b1;
        @(posedge clk); #1;
        total++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_valid !== 1'b0) begin
            bad++;
            $display("FAIL done_to_idle rdy=%0b busy=%0b vld=%0b want 1 0 0",
                     o_ready, o_busy, o_valid);
        end
        @(posedge clk); #1;
        valid = 1'b0;
        total++;
        if (o_busy !== 1'b1) begin
            bad++; $display("FAIL next_accept busy=%0b want=1", o_busy);
        end
        wait_valid(lat);
        total++;
        if (plain !== PV) begin
            bad++; $display("FAIL next_plain got=%b want=%b", plain, PV);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midop();
        logic [7:0] r;
        int lat;
        ready = 1'b1;
        accept_req(CV, KV, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL midrst_flags vld=%0b rdy=%0b busy=%0b want 0 1 0",
                     o_valid, o_ready, o_busy);
        end
        total++;
        if (plain !== 8'h00) begin
            bad++; $display("FAIL midrst_plain got=%h want=00", plain);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (o_valid !== 1'b0) begin
                bad++; $display("FAIL midrst_novalid got=%0b want=0", o_valid);
            end
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_one(CV, KV, 1'b0, r, lat);
        total++;
        if (r !== PV || lat + 1 !== 4) begin
            bad++;
            $display("FAIL midrst_after got=%b lat=%0d want=%b 4", r, lat + 1, PV);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] k;
        logic [7:0] expq[$];
        logic [7:0] e;
        logic pre;
        int cyc;
        int last;
        int nacc;
        int nres;
        k = 10'b1100011110;
        cyc = 0; last = 0; nacc = 0; nres = 0;
        ready  = 1'b1;
        key    = k;
        cipher = 8'h00;
        valid  = 1'b1;
        while (nres < 256 && cyc < 2000) begin
            pre = o_ready && valid;
            @(posedge clk); #1;
            cyc++;
            if (pre) begin
                expq.push_back(model(cipher, k, 1'b0));
                if (nacc > 0) begin
                    total++;
                    if (cyc - last !== 5) begin
                        bad++;
                        $display("FAIL b2b_interval n=%0d got=%0d want=5", nacc, cyc - last);
                    end
                end
                last = cyc;
                nacc++;
                if (nacc == 256) valid = 1'b0;
                else cipher = nacc[7:0];
            end
            if (o_valid) begin
                e = (expq.size() > 0) ? expq.pop_front() : 8'hxx;
                total++;
                if (plain !== e) begin
                    bad++;
                    $display("FAIL b2b_plain n=%0d got=%h want=%h", nres, plain, e);
                end
                nres++;
            end
        end
        valid = 1'b0;
        total++;
        if (nres !== 256) begin
            bad++; $display("FAIL b2b_count got=%0d want=256", nres);
        end
        @(posedge clk); #1;
    endtask

`ifdef SDES_DEC_ENCRYPT_EN
    task automatic test_encrypt();
        logic [7:0] r;
        logic [7:0] c;
        logic [7:0] p;
        logic [9:0] k;
        int lat;
        ready = 1'b1;
        run_one(PV, KV, 1'b1, r, lat);
        total++;
        if (r !== CV || lat + 1 !== 4) begin
            bad++;
            $display("FAIL enc_known got=%b lat=%0d want=%b 4", r, lat + 1, CV);
        end
        for (int i = 0; i < 1000; i++) begin
            k = 10'($urandom_range(0, 1023));
            p = 8'($urandom_range(0, 255));
            run_one(p, k, 1'b1, c, lat);
            total++;
            if (c !== model(p, k, 1'b1)) begin
                bad++;
                $display("FAIL enc_model i=%0d got=%h want=%h", i, c, model(p, k, 1'b1));
            end
            run_one(c, k, 1'b0, r, lat);
            total++;
            if (r !== p) begin
                bad++; $display("FAIL round_trip i=%0d got=%h want=%h", i, r, p);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_known();
        test_backpressure();
        test_input_change();
        test_done_valid();
        test_reset_midop();
        test_back_to_back();
`ifdef SDES_DEC_ENCRYPT_EN
        test_encrypt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
